// File: rtl/ternary_to_binary_decoder.sv
// ternary_to_binary_decoder
//   Converts a balanced-ternary word (two bits per trit) into a signed
//   two's-complement integer. One trit is consumed per clock, MSB first,
//   using Horner evaluation: acc = acc*3 + trit.
//
//   Trit codes: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal.
//   An illegal trit contributes 0 and sets the sticky error flag for the word.
//
// Ports
//   clock      rising-edge system clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_word holds a word to convert
//   in_ready   decoder is idle and will accept a word
//   in_word    trit i at bits [2i+1:2i]; trit WORD_SIZE-1 is the MSB
//   out_valid  out_value/out_error hold a finished result
//   out_ready  consumer takes the result
//   out_value  signed result, BIN_WIDTH bits
//   out_error  at least one trit of the word was illegal
module ternary_to_binary_decoder #(
  parameter int WORD_SIZE = 9,
  parameter int BIN_WIDTH = 15
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WORD_SIZE-1:0] in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_WIDTH-1:0]   out_value,
  output logic                   out_error
);

  // Elaboration-time range check: the widest magnitude (3^N-1)/2 must fit.
  function automatic longint unsigned pow3(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 3;
    return p;
  endfunction

  localparam longint unsigned MAX_MAG = (pow3(WORD_SIZE) - 1) / 2;
  localparam longint unsigned BIN_LIM = longint'(1) << (BIN_WIDTH - 1);

  if (!(BIN_LIM > MAX_MAG)) begin : g_bad_params
    $error("BIN_WIDTH too small for WORD_SIZE trits");
  end

  localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int SH_W  = 2 * WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [BIN_WIDTH-1:0]   acc_q,   acc_d;
  logic                   err_q,   err_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [BIN_WIDTH-1:0]   value_q, value_d;
  logic                   error_q, error_d;

  logic [1:0]             trit;
  logic [BIN_WIDTH-1:0]   trit_val;

  // The word is shifted left two bits per cycle, so the trit being
  // evaluated always sits at the top of the shift register.
  assign trit = shift_q[SH_W-1 -: 2];

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    err_d    = err_q;
    idx_d    = idx_q;
    value_d  = value_q;
    error_d  = error_q;
    trit_val = '0;

    unique case (trit)
      2'b01:   trit_val = BIN_WIDTH'(1);
      2'b11:   trit_val = '1;           // -1, sign-extended
      default: trit_val = '0;           // 0 and the illegal code
    endcase

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_word;
          acc_d   = '0;
          err_d   = 1'b0;
          idx_d   = IDX_W'(WORD_SIZE - 1);
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        acc_d   = (acc_q << 1) + acc_q + trit_val;
        err_d   = err_q | (trit == 2'b10);
        shift_d = shift_q << 2;
        if (idx_q == '0) begin
          // The output register only ever sees a completed word, so an
          // aborted or in-flight conversion is never visible on out_value.
          value_d = acc_d;
          error_d = err_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      value_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      error_q <= error_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_value = value_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_ternary_to_binary_decoder.sv
// Testbench for ternary_to_binary_decoder.
//   The driver pushes the expected result of each accepted word into a
//   scoreboard queue; an independent monitor pops and compares whenever the
//   decoder completes an output handshake, and checks the accept-to-valid
//   latency. Random words are scored with an arithmetic reference model.
module tb_ternary_to_binary_decoder;

  localparam int W  = 9;
  localparam int BW = 15;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*W-1:0]    in_word  = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BW-1:0]     out_value;
  logic              out_error;

  ternary_to_binary_decoder #(.WORD_SIZE(W), .BIN_WIDTH(BW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_error (out_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int value;
    bit err;
    int acc_edge;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value = sum over trits of digit * 3^position.
  function automatic exp_t model(input logic [2*W-1:0] w);
    exp_t r;
    int   p;
    r.value = 0;
    r.err = 1'b0;
    r.acc_edge = 0;
    p = 1;
    for (int i = 0; i < W; i++) begin
      case (w[2*i +: 2])
        2'b01:   r.value += p;
        2'b11:   r.value -= p;
        2'b10:   r.err = 1'b1;
        default: ;
      endcase
      p *= 3;
    end
    return r;
  endfunction

  // Build a word from digits listed MSB first; 2 stands for the illegal code.
  function automatic logic [2*W-1:0] mk(input int t[W]);
    logic [2*W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      case (t[k])
        0:       w[2*(W-1-k) +: 2] = 2'b00;
        1:       w[2*(W-1-k) +: 2] = 2'b01;
        -1:      w[2*(W-1-k) +: 2] = 2'b11;
        default: w[2*(W-1-k) +: 2] = 2'b10;
      endcase
    end
    return w;
  endfunction

  function automatic exp_t ex(input int value, input bit err);
    exp_t e;
    e.value = value;
    e.err = err;
    e.acc_edge = 0;
    return e;
  endfunction

  // Present a word, wait for acceptance, record its expected result.
  task automatic send(input logic [2*W-1:0] w, input exp_t e);
    bit done;
    done = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_word  = 2*W'($urandom);   // must not disturb the word in flight
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor
  bit prev_valid = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency_edges", cyc - sb[0].acc_edge + 1, W + 1);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_value", int'($signed(out_value)), e.value);
        check("out_error", int'(out_error), int'(e.err));
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [2*W-1:0] w118, wm107, w225, wpos, wneg, wzero, wbad, wr;
  int             n;

  initial begin
    w118  = mk('{0, 0, 0, 0, 1, 1, 1, 0, 1});
    wm107 = mk('{0, 0, 0, 0, -1, -1, 0, 0, 1});
    w225  = mk('{0, 0, 0, 1, 0, -1, 1, 0, 0});
    wpos  = mk('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    wneg  = mk('{-1, -1, -1, -1, -1, -1, -1, -1, -1});
    wzero = mk('{0, 0, 0, 0, 0, 0, 0, 0, 0});
    wbad  = mk('{0, 0, 0, 0, 0, 2, 0, 0, 1});

    // Reset with in_valid asserted: nothing may be accepted.
    in_valid = 1'b1;
    in_word  = w118;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_value", int'(out_value), 0);
    check("rst_out_error", int'(out_error), 0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Directed decodes and extremes.
    send(w118,  ex(118, 1'b0));   drain();
    send(wm107, ex(-107, 1'b0));  drain();
    send(w225,  ex(225, 1'b0));   drain();
    send(wpos,  ex(9841, 1'b0));  drain();
    send(wneg,  ex(-9841, 1'b0)); drain();
    send(wzero, ex(0, 1'b0));     drain();

    // Back-to-back throughput: second word accepted W+2 edges after the first.
    send(w118, ex(118, 1'b0));
    n = cyc;
    send(w225, ex(225, 1'b0));
    check("throughput_edges", cyc - n, W + 2);
    drain();

    // Backpressure.
    out_ready = 1'b0;
    send(w225, ex(225, 1'b0));
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("bp_reach_done", int'(out_valid), 1);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_word  = wpos;
      @(posedge clock);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_value", int'($signed(out_value)), 225);
      check("bp_in_ready",  int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_value_retained", int'($signed(out_value)), 225);
    repeat (15) @(posedge clock);
    #1;
    check("bp_no_extra_accept", int'(in_ready), 1);

    // Illegal code, then a legal word clears the error.
    send(wbad, ex(1, 1'b1)); drain();
    send(w118, ex(118, 1'b0)); drain();

    // Reset in convert cycle 4 aborts the word.
    send(w118, ex(118, 1'b0));
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    sb.delete();
    @(posedge clock);
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_value", int'(out_value), 0);
    check("abort_in_ready",  int'(in_ready), 1);
    reset_n = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check("abort_idle", int'(out_valid), 0);
    send(wm107, ex(-107, 1'b0)); drain();

    // Randomized words scored by the arithmetic model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < W; i++) begin
        case ($urandom_range(0, 7))
          0:       wr[2*i +: 2] = 2'b10;
          1, 2:    wr[2*i +: 2] = 2'b00;
          3, 4, 5: wr[2*i +: 2] = 2'b01;
          default: wr[2*i +: 2] = 2'b11;
        endcase
      end
      send(wr, model(wr));
      drain();
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    repeat (5) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
